ray_direction_scanner: RTL and testbench
========================================

Name: ray_direction_scanner

Overview:
- Sequential, parametrised successor to the combinational per-pixel direction-vector stage.
- On a start pulse it latches camera, first-pixel and per-pixel-delta locations, then walks every pixel of an H_RES x V_RES frame in raster order.
- Emits one direction vector per pixel over a valid/ready stream, with row/frame markers, to the downstream ray-intersection pipeline.
- Replaces per-pixel multipliers with incremental accumulation.

Parameters:
- COORD_W, 12, width of each vector component and location coordinate.
- H_RES, 640, pixels per row (column count), >= 1.
- V_RES, 480, rows per frame, >= 1.
- COL_W, $clog2(H_RES) min 1, column counter width (derived).
- ROW_W, $clog2(V_RES) min 1, row counter width (derived).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- camera_location  in  [2:0][COORD_W-1:0]  camera position.
- beginning_pixel_location  in  [2:0][COORD_W-1:0]  location of pixel (0,0).
- pixels_delta_location  in  [2:0][COORD_W-1:0]  per-pixel step.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final vector is accepted.
- vec_valid  out  1  vector available.
- vec_ready  in  1  consumer accepts.
- vector  out  [2:0][COORD_W-1:0]  direction vector.
- pixel_col  out  [COL_W-1:0]  column of current vector.
- pixel_row  out  [ROW_W-1:0]  row of current vector.
- last_in_row  out  1  col == H_RES-1.
- last_in_frame  out  1  col == H_RES-1 and row == V_RES-1.

Behaviour:
- Reset: asynchronous, active-low. All outputs and internal registers are 0; state = IDLE.
- Vector definition, all arithmetic modulo 2^COORD_W with the product truncated to COORD_W:
  - v0 = cam0 - beg0 - col*d0
  - v1 = cam1 - beg1 - row*d1
  - v2 = cam2 - beg2 + col*d2
- Implementation method is incremental:
  - Row base: b1 = cam1 - beg1, decremented by d1 per row.
  - Column accumulators: a0 = cam0 - beg0, minus d0 per column; a2 = cam2 - beg2, plus d2 per column. Both reload their base at each row start.
  - Results must be bit-identical to the multiply form.
- States:
  - IDLE -> LOAD on start. At that edge, latch the deltas and bases (cam - beg), set col = row = 0, raise busy.
  - LOAD -> RUN after one cycle. At that edge the output register is loaded with pixel (0,0) and vec_valid goes high. Start-to-first-valid latency is 2 cycles.
  - RUN: output register loads the next pixel when (!vec_valid || vec_ready). Throughput is one vector per cycle under continuous ready.
  - Column wrap: col H_RES-1 -> 0, row increments, column accumulators reload.
  - After the last_in_frame vector handshakes: vec_valid drops; state FINISH.
  - FINISH -> IDLE after one cycle, with done = 1 for exactly that cycle and busy dropping to 0.
- Backpressure: while vec_valid && !vec_ready, vector, pixel_col, pixel_row, last_in_row and last_in_frame hold stable. No counter or accumulator advances.
- start while busy is ignored. Input location ports are don't-care outside the start cycle.
- H_RES = 1 or V_RES = 1: last_in_row is 1 on every vector (H_RES = 1), and the frame ends correctly.
- Reset mid-frame: immediate return to IDLE. No done pulse, vec_valid = 0.
- A consumer that never asserts ready stalls the block indefinitely, with no timeout.

Decomposition:
- Shared package ray_pkg:
  - COORD_W default constant.
  - vec3_t typedef, [2:0][COORD_W-1:0].
  - Scanner state enum {IDLE, LOAD, RUN, FINISH}.
- One natural sub-module, raster_counter: col/row counters with enable, wrap, last_in_row/last_in_frame flags, parametrised by H_RES and V_RES.
- Accumulators and FSM stay in the top module.

Test Plan:
- Common setup: H_RES=4, V_RES=3, cam=(100,200,300), beg=(10,20,30), d=(2,3,5), ready tied 1.
- Basic frame: start -> vec_valid 2 cycles after start. Required vectors:
  - (0,0) = (90,180,270)
  - (3,0) = (84,180,285), last_in_row = 1
  - (0,1) = (90,177,270)
  - (3,2) = (84,174,285), last_in_frame = 1
  - 12 vectors on consecutive cycles; done pulses one cycle after the last; busy then 0.
- Wrap-around: cam0=0, beg0=1, d0=1 -> v0 is 4095, 4094, 4093, 4092 across each row. Compare all 12 vectors to the multiply-form model.
- Backpressure: ready low for 5 cycles at pixel (2,1) -> outputs hold (86,177,280) unchanged. The next pixel appears only after the ready-high handshake. No vector is lost or duplicated.
- Random ready (50%) with random locations, H_RES=5, V_RES=2 -> scoreboard matches the model for all 10 pixels, in order. Exactly one done pulse.
- Control: start pulsed during RUN is ignored (frame count stays 1). rst_n low at pixel 6 -> all outputs 0 asynchronously, no done. A fresh start afterwards produces a full 12-vector frame.

Source files
------------

// File: rtl/ray_pkg.sv
// rtl/ray_pkg.sv - shared types and constants for the ray direction scanner
package ray_pkg;
  localparam int DEFAULT_COORD_W = 12;

  typedef logic [2:0][DEFAULT_COORD_W-1:0] vec3_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} scan_state_t;
endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster-order column/row counter with end-of-row/frame flags
module raster_counter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1,
  parameter int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_in_row,
  output logic             last_in_frame
);
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  assign col           = col_q;
  assign row           = row_q;
  assign last_in_row   = (col_q == COL_W'(H_RES - 1));
  assign last_in_frame = last_in_row && (row_q == ROW_W'(V_RES - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (last_in_row) begin
        col_d = '0;
        row_d = last_in_frame ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/ray_direction_scanner.sv
// rtl/ray_direction_scanner.sv - streams one camera-ray direction vector per pixel in raster order
module ray_direction_scanner
  import ray_pkg::*;
#(
  parameter int COORD_W = DEFAULT_COORD_W,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COL_W   = (H_RES > 1) ? $clog2(H_RES) : 1,
  parameter int ROW_W   = (V_RES > 1) ? $clog2(V_RES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2:0][COORD_W-1:0] camera_location,
  input  logic [2:0][COORD_W-1:0] beginning_pixel_location,
  input  logic [2:0][COORD_W-1:0] pixels_delta_location,
  output logic                    busy,
  output logic                    done,
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic [2:0][COORD_W-1:0] vector,
  output logic [COL_W-1:0]        pixel_col,
  output logic [ROW_W-1:0]        pixel_row,
  output logic                    last_in_row,
  output logic                    last_in_frame
);
  scan_state_t               state_q, state_d;
  logic                      busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [2:0][COORD_W-1:0]   vec_q, vec_d, delta_q, delta_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic                      lir_q, lir_d, lif_q, lif_d;
  logic [COORD_W-1:0]        base0_q, base0_d, base2_q, base2_d;
  logic [COORD_W-1:0]        a0_q, a0_d, a2_q, a2_d, b1_q, b1_d;

  logic                      cnt_clr, cnt_en, load_out;
  logic [COL_W-1:0]          cnt_col;
  logic [ROW_W-1:0]          cnt_row;
  logic                      cnt_lir, cnt_lif;

  // The counter and accumulators always describe the next pixel to be emitted.
  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_raster (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (cnt_clr),
    .en            (cnt_en),
    .col           (cnt_col),
    .row           (cnt_row),
    .last_in_row   (cnt_lir),
    .last_in_frame (cnt_lif)
  );

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    valid_d  = valid_q;
    vec_d    = vec_q;
    delta_d  = delta_q;
    col_d    = col_q;
    row_d    = row_q;
    lir_d    = lir_q;
    lif_d    = lif_q;
    base0_d  = base0_q;
    base2_d  = base2_q;
    a0_d     = a0_q;
    a2_d     = a2_q;
    b1_d     = b1_q;
    cnt_clr  = 1'b0;
    load_out = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        busy_d  = 1'b1;
        cnt_clr = 1'b1;
        delta_d = pixels_delta_location;
        base0_d = camera_location[0] - beginning_pixel_location[0];
        base2_d = camera_location[2] - beginning_pixel_location[2];
        a0_d    = camera_location[0] - beginning_pixel_location[0];
        a2_d    = camera_location[2] - beginning_pixel_location[2];
        b1_d    = camera_location[1] - beginning_pixel_location[1];
      end
      LOAD: begin
        state_d  = RUN;
        valid_d  = 1'b1;
        load_out = 1'b1;
      end
      RUN: begin
        if (valid_q && vec_ready && lif_q) begin
          state_d = FINISH;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else if (!valid_q || vec_ready) begin
          valid_d  = 1'b1;
          load_out = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (load_out) begin
      vec_d = {a2_q, b1_q, a0_q};
      col_d = cnt_col;
      row_d = cnt_row;
      lir_d = cnt_lir;
      lif_d = cnt_lif;
      if (cnt_lir) begin
        a0_d = base0_q;
        a2_d = base2_q;
        b1_d = b1_q - delta_q[1];
      end else begin
        a0_d = a0_q - delta_q[0];
        a2_d = a2_q + delta_q[2];
      end
    end
    cnt_en = load_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      vec_q   <= '0;
      delta_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      lir_q   <= 1'b0;
      lif_q   <= 1'b0;
      base0_q <= '0;
      base2_q <= '0;
      a0_q    <= '0;
      a2_q    <= '0;
      b1_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      vec_q   <= vec_d;
      delta_q <= delta_d;
      col_q   <= col_d;
      row_q   <= row_d;
      lir_q   <= lir_d;
      lif_q   <= lif_d;
      base0_q <= base0_d;
      base2_q <= base2_d;
      a0_q    <= a0_d;
      a2_q    <= a2_d;
      b1_q    <= b1_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign vec_valid     = valid_q;
  assign vector        = vec_q;
  assign pixel_col     = col_q;
  assign pixel_row     = row_q;
  assign last_in_row   = lir_q;
  assign last_in_frame = lif_q;
endmodule

// File: tb/tb_ray_direction_scanner.sv
// tb/tb_ray_direction_scanner.sv - self-checking bench for ray_direction_scanner
module tb_ray_direction_scanner;
  import ray_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vec3_t cam, beg, dl;
  logic  start_a, start_b, ready_a, ready_b;

  logic       busy_a, done_a, valid_a, lir_a, lif_a;
  vec3_t      vector_a;
  logic [1:0] col_a, row_a;
  logic       busy_b, done_b, valid_b, lir_b, lif_b;
  vec3_t      vector_b;
  logic [2:0] col_b;
  logic [0:0] row_b;

  ray_direction_scanner #(.COORD_W(12), .H_RES(4), .V_RES(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .camera_location(cam), .beginning_pixel_location(beg), .pixels_delta_location(dl),
    .busy(busy_a), .done(done_a), .vec_valid(valid_a), .vec_ready(ready_a),
    .vector(vector_a), .pixel_col(col_a), .pixel_row(row_a),
    .last_in_row(lir_a), .last_in_frame(lif_a)
  );

  ray_direction_scanner #(.COORD_W(12), .H_RES(5), .V_RES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .camera_location(cam), .beginning_pixel_location(beg), .pixels_delta_location(dl),
    .busy(busy_b), .done(done_b), .vec_valid(valid_b), .vec_ready(ready_b),
    .vector(vector_b), .pixel_col(col_b), .pixel_row(row_b),
    .last_in_row(lir_b), .last_in_frame(lif_b)
  );

  int errors = 0, checks = 0;
  int sel = 0, k = 0, done_cnt = 0, cyc = 0;
  bit chk_en = 0, exp_done = 0, rnd_en = 0;
  vec3_t got [0:15];
  int    got_cyc [0:15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Multiply-form reference for pixel (c, r).
  function automatic vec3_t model_vec(input int c, input int r);
    vec3_t v;
    v[0] = cam[0] - beg[0] - 12'(c * int'(dl[0]));
    v[1] = cam[1] - beg[1] - 12'(r * int'(dl[1]));
    v[2] = cam[2] - beg[2] + 12'(c * int'(dl[2]));
    return v;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) if (rnd_en) begin
    #1 ready_b = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) if (chk_en) begin
    logic  o_valid, o_ready, o_done, o_lir, o_lif;
    vec3_t o_vec;
    int    o_col, o_row, hres, vres, total, ec, er;
    bit    nd;
    if (sel == 0) begin
      o_valid = valid_a; o_ready = ready_a; o_done = done_a; o_vec = vector_a;
      o_col = int'(col_a); o_row = int'(row_a); o_lir = lir_a; o_lif = lif_a;
      hres = 4; vres = 3;
    end else begin
      o_valid = valid_b; o_ready = ready_b; o_done = done_b; o_vec = vector_b;
      o_col = int'(col_b); o_row = int'(row_b); o_lir = lir_b; o_lif = lif_b;
      hres = 5; vres = 2;
    end
    total = hres * vres;
    check("done", 64'(o_done), 64'(exp_done));
    if (o_done) done_cnt++;
    if (o_valid) begin
      if (k >= total) begin
        check("extra_vec", 64'(1), 64'(0));
      end else begin
        ec = k % hres;
        er = k / hres;
        check("vector", 64'(o_vec), 64'(model_vec(ec, er)));
        check("col", 64'(o_col), 64'(ec));
        check("row", 64'(o_row), 64'(er));
        check("last_in_row", 64'(o_lir), 64'(ec == hres - 1));
        check("last_in_frame", 64'(o_lif), 64'(k == total - 1));
      end
    end
    nd = o_valid && o_ready && (k == total - 1);
    if (o_valid && o_ready) begin
      if (k < 16) begin
        got[k]     = o_vec;
        got_cyc[k] = cyc;
      end
      k++;
    end
    exp_done = nd;
  end

  task automatic pulse_start(input int which);
    @(posedge clk); #1;
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_timeout", 64'(done_cnt > base), 64'(1));
  endtask

  task automatic wait_pix_a(input int c, input int r);
    int  n = 0;
    bit  found = 0;
    while (!found && n < 100) begin
      @(posedge clk); #1;
      found = valid_a && int'(col_a) == c && int'(row_a) == r;
      n++;
    end
    check("find_pixel", 64'(found), 64'(1));
  endtask

  task automatic basic_setup();
    cam = {12'd300, 12'd200, 12'd100};
    beg = {12'd30, 12'd20, 12'd10};
    dl  = {12'd5, 12'd3, 12'd2};
  endtask

  initial begin
    rst_n = 1'b0; start_a = 0; start_b = 0; ready_a = 0; ready_b = 0;
    cam = '0; beg = '0; dl = '0;
    repeat (3) @(negedge clk);
    check("reset_a", 64'({busy_a, done_a, valid_a, vector_a, col_a, row_a, lir_a, lif_a}), 64'(0));
    check("reset_b", 64'({busy_b, done_b, valid_b, vector_b, col_b, row_b, lir_b, lif_b}), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic frame with latency and literal pins.
    basic_setup();
    sel = 0; k = 0; exp_done = 0; ready_a = 1; chk_en = 1;
    pulse_start(0);
    @(negedge clk);
    check("lat1_valid", 64'(valid_a), 64'(0));
    check("lat1_busy", 64'(busy_a), 64'(1));
    @(negedge clk);
    check("lat2_valid", 64'(valid_a), 64'(1));
    wait_done(0);
    check("pix00", 64'(got[0]), 64'({12'd270, 12'd180, 12'd90}));
    check("pix30", 64'(got[3]), 64'({12'd285, 12'd180, 12'd84}));
    check("pix01", 64'(got[4]), 64'({12'd270, 12'd177, 12'd90}));
    check("pix32", 64'(got[11]), 64'({12'd285, 12'd174, 12'd84}));
    check("consecutive", 64'(got_cyc[11] - got_cyc[0]), 64'(11));
    check("count1", 64'(k), 64'(12));
    @(negedge clk);
    check("busy_after", 64'(busy_a), 64'(0));

    // Modular wrap-around of component 0.
    cam[0] = 12'd0; beg[0] = 12'd1; dl[0] = 12'd1;
    k = 0;
    pulse_start(0);
    wait_done(1);
    check("wrap0", 64'(got[0][0]), 64'(4095));
    check("wrap3", 64'(got[3][0]), 64'(4092));
    check("wrap4", 64'(got[4][0]), 64'(4095));

    // Backpressure at pixel (2,1) plus a start pulse that must be ignored.
    basic_setup();
    k = 0;
    pulse_start(0);
    wait_pix_a(2, 1);
    ready_a = 0; start_a = 1;
    repeat (5) begin
      @(negedge clk);
      check("hold_vec", 64'(vector_a), 64'({12'd280, 12'd177, 12'd86}));
      @(posedge clk); #1 start_a = 0;
    end
    ready_a = 1;
    wait_done(2);
    check("bp_pix6", 64'(got[6]), 64'({12'd280, 12'd177, 12'd86}));
    check("bp_pix7", 64'(got[7]), 64'({12'd285, 12'd177, 12'd84}));
    check("bp_count", 64'(k), 64'(12));
    repeat (10) @(negedge clk);
    check("ignored_start", 64'({valid_a, busy_a}), 64'(0));
    check("frames_a", 64'(done_cnt), 64'(3));

    // Random locations and random ready on the 5x2 instance.
    for (int i = 0; i < 3; i++) begin
      cam[i] = 12'($urandom);
      beg[i] = 12'($urandom);
      dl[i]  = 12'($urandom);
    end
    sel = 1; k = 0; exp_done = 0;
    rnd_en = 1;
    pulse_start(1);
    wait_done(3);
    rnd_en = 0;
    repeat (5) @(negedge clk);
    #1;
    check("rand_count", 64'(k), 64'(10));
    check("rand_one_done", 64'(done_cnt), 64'(4));
    ready_b = 0;

    // Asynchronous reset mid-frame, then a fresh full frame.
    basic_setup();
    sel = 0; k = 0; exp_done = 0; ready_a = 1;
    pulse_start(0);
    wait_pix_a(2, 1);
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    check("rst_async", 64'({busy_a, done_a, valid_a, vector_a, col_a, row_a, lir_a, lif_a}), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", 64'(done_a), 64'(0));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    k = 0; exp_done = 0; chk_en = 1;
    pulse_start(0);
    wait_done(4);
    check("fresh_count", 64'(k), 64'(12));
    check("fresh_pix32", 64'(got[11]), 64'({12'd285, 12'd174, 12'd84}));
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
